// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bundle for sram_ctrl.
// master: load/store unit side; slave: the controller.
interface sram_ctrl_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              req;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              ready;
   logic              done;
   logic              err;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, req_we, req_addr, req_wdata,
      input  ready, done, err, rdata
   );

   modport slave (
      input  req, req_we, req_addr, req_wdata,
      output ready, done, err, rdata
   );
endinterface

// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous SRAM.
// Each accepted word access walks SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> DONE, with every
// output registered. Misaligned requests take a single ERR cycle and touch no strobe.
module sram_ctrl #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned WAIT_CYCLES = 2   // legal range 1..15
) (
   input  logic              clk,
   input  logic              rst,
   sram_ctrl_if.slave        bus,
   output logic              sram_cs,
   output logic              sram_oe,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_din,
   input  logic [DATA_W-1:0] sram_dout
);

   typedef enum logic [2:0] {
      StIdle,
      StErr,
      StSetup,
      StAccess,
      StHold,
      StDone
   } state_e;

   state_e            state_q;
   logic [3:0]        cnt_q;
   logic              wr_q;
   logic              ready_q;
   logic              done_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;

   assign bus.ready = ready_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

   // Access sequencer; outputs are set on the edge entering the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         wr_q      <= 1'b0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
         sram_cs   <= 1'b0;
         sram_oe   <= 1'b0;
         sram_we   <= 1'b0;
         sram_addr <= '0;
         sram_din  <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            StIdle: begin
               if (bus.req) begin
                  ready_q <= 1'b0;
                  if (bus.req_addr[1:0] != 2'b00) begin
                     err_q   <= 1'b1;
                     state_q <= StErr;
                  end else begin
                     wr_q      <= bus.req_we;
                     sram_cs   <= 1'b1;
                     sram_addr <= bus.req_addr;
                     sram_din  <= bus.req_wdata;
                     state_q   <= StSetup;
                  end
               end
            end
            StErr: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            StSetup: begin
               // Address has been stable a full cycle before the strobe rises.
               sram_oe <= ~wr_q;
               sram_we <= wr_q;
               cnt_q   <= 4'(WAIT_CYCLES - 1);
               state_q <= StAccess;
            end
            StAccess: begin
               if (cnt_q == 4'd0) begin
                  if (!wr_q) begin
                     rdata_q <= sram_dout;
                  end
                  sram_oe <= 1'b0;
                  sram_we <= 1'b0;
                  state_q <= StHold;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StHold: begin
               // cs/addr/din stayed put for one cycle after we fell.
               sram_cs <= 1'b0;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               ready_q <= 1'b1;
               state_q <= StIdle;
            end
            default: begin
               ready_q <= 1'b1;
               sram_cs <= 1'b0;
               sram_oe <= 1'b0;
               sram_we <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: a cycle-offset model of the access timeline checked every cycle,
// plus directed accesses with literal expectations. A second instance uses WAIT_CYCLES=1.
module tb_sram_ctrl;

   localparam int W = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_on = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   sram_ctrl_if #(.ADDR_W(32), .DATA_W(32)) a_if ();
   sram_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b_if ();

   logic        a_cs, a_oe, a_we, b_cs, b_oe, b_we;
   logic [31:0] a_addr, a_din, a_dout, b_addr, b_din, b_dout;

   sram_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(rst), .bus(a_if),
      .sram_cs(a_cs), .sram_oe(a_oe), .sram_we(a_we),
      .sram_addr(a_addr), .sram_din(a_din), .sram_dout(a_dout)
   );

   sram_ctrl #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .bus(b_if),
      .sram_cs(b_cs), .sram_oe(b_oe), .sram_we(b_we),
      .sram_addr(b_addr), .sram_din(b_din), .sram_dout(b_dout)
   );

   // Initial memory contents ("data file").
   function automatic logic [31:0] preload(input logic [7:0] idx);
      if (idx == 8'h08) return 32'h1234_5678;
      return 32'hA500_0000 | {24'h0, idx};
   endfunction

   // SRAM models: asynchronous read, write taken while cs&we are high at an edge.
   logic [31:0] sram_mem [256];
   logic        sram_init = 1'b0;
   always @(posedge clk) begin
      if (!sram_init) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= preload(8'(i));
         sram_init <= 1'b1;
      end else if (a_cs && a_we) begin
         sram_mem[a_addr[9:2]] <= a_din;
      end
   end
   assign a_dout = (a_cs && a_oe) ? sram_mem[a_addr[9:2]] : 32'hDEAD_BEEF;
   assign b_dout = (b_cs && b_oe) ? preload(b_addr[9:2]) : 32'hDEAD_BEEF;

   // Reference model: m_k counts cycles since the accepting edge (0 = idle).
   int          m_k = 0;
   logic        m_mis = 1'b0, m_wr = 1'b0;
   logic [31:0] m_addr = '0, m_din = '0, m_rdata = '0;
   logic [31:0] ref_mem [256];
   logic        ref_init = 1'b0;
   always @(posedge clk) begin
      if (!ref_init) begin
         for (int i = 0; i < 256; i++) ref_mem[i] <= preload(8'(i));
         ref_init <= 1'b1;
      end
      if (rst) begin
         m_k <= 0; m_mis <= 1'b0; m_addr <= '0; m_din <= '0; m_rdata <= '0;
      end else if (m_k == 0) begin
         if (a_if.req) begin
            m_k   <= 1;
            m_mis <= (a_if.req_addr[1:0] != 2'b00);
            m_wr  <= a_if.req_we;
            if (a_if.req_addr[1:0] == 2'b00) begin
               m_addr <= a_if.req_addr;
               m_din  <= a_if.req_wdata;
            end
         end
      end else begin
         m_k <= ((m_mis && m_k == 1) || m_k == W + 3) ? 0 : m_k + 1;
         if (!m_mis && m_wr && m_k == 2) ref_mem[m_addr[9:2]] <= m_din;
         if (!m_mis && !m_wr && m_k == W + 1) m_rdata <= ref_mem[m_addr[9:2]];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Per-cycle comparison of instance A against the model.
   always @(negedge clk) begin
      if (chk_on) begin : cmp
         logic good;
         good = !m_mis && m_k != 0;
         check("ready", 32'(a_if.ready), 32'(m_k == 0));
         check("err", 32'(a_if.err), 32'(m_mis && m_k == 1));
         check("done", 32'(a_if.done), 32'(good && m_k == W + 3));
         check("cs", 32'(a_cs), 32'(good && m_k <= W + 2));
         check("oe", 32'(a_oe), 32'(good && !m_wr && m_k >= 2 && m_k <= W + 1));
         check("we", 32'(a_we), 32'(good && m_wr && m_k >= 2 && m_k <= W + 1));
         check("addr", a_addr, m_addr);
         check("din", a_din, m_din);
         check("rdata", a_if.rdata, m_rdata);
      end
   end

   // One access on instance A; collects strobe counts and event cycles relative to accept.
   task automatic run_a(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int n_we, output int n_oe, output int n_err, output int n_cs,
                        output int done_at, output int ready_at, output logic [31:0] rd);
      n_we = 0; n_oe = 0; n_err = 0; n_cs = 0; done_at = 0; ready_at = 0; rd = '0;
      @(negedge clk);
      a_if.req = 1'b1; a_if.req_we = we; a_if.req_addr = addr; a_if.req_wdata = wdata;
      @(negedge clk);
      a_if.req = 1'b0;
      for (int k = 1; k < 40; k++) begin
         if (a_we) n_we++;
         if (a_oe) n_oe++;
         if (a_cs) n_cs++;
         if (a_if.err) n_err++;
         if (a_if.done) begin done_at = k; rd = a_if.rdata; end
         if (a_if.ready) begin ready_at = k; break; end
         @(negedge clk);
      end
      if (ready_at == 0) check("access_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_idle_a();
      int n = 0;
      while (!a_if.ready && n < 50) begin @(negedge clk); n++; end
      if (!a_if.ready) check("idle_timeout", 32'd0, 32'd1);
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin : stim
      int          nwe, noe, nerr, ncs, dat, rat, ndone;
      logic [31:0] rd;
      logic [31:0] addrs [4];
      int          acc [$];

      addrs[0] = 32'h0040_003C; addrs[1] = 32'h1000_0024;
      addrs[2] = 32'h0040_0020; addrs[3] = 32'h0040_0024;
      a_if.req = 1'b0; a_if.req_we = 1'b0; a_if.req_addr = '0; a_if.req_wdata = '0;
      b_if.req = 1'b0; b_if.req_we = 1'b0; b_if.req_addr = '0; b_if.req_wdata = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;
      check("rst_ready", 32'(a_if.ready), 32'd1);
      check("rst_cs", 32'(a_cs), 32'd0);
      check("rst_rdata", a_if.rdata, 32'd0);

      // Write 0xE to 0x0040003C.
      run_a(1'b1, 32'h0040_003C, 32'h0000_000E, nwe, noe, nerr, ncs, dat, rat, rd);
      check("wr_we_cycles", 32'(nwe), 32'd2);
      check("wr_oe_cycles", 32'(noe), 32'd0);
      check("wr_done_at", 32'(dat), 32'd5);
      check("wr_ready_at", 32'(rat), 32'd6);

      // Read it back.
      run_a(1'b0, 32'h0040_003C, 32'h0, nwe, noe, nerr, ncs, dat, rat, rd);
      check("rd_oe_cycles", 32'(noe), 32'd2);
      check("rd_we_cycles", 32'(nwe), 32'd0);
      check("rd_done_at", 32'(dat), 32'd5);
      check("rd_data", rd, 32'h0000_000E);
      repeat (2) @(negedge clk);
      check("rd_data_held", a_if.rdata, 32'h0000_000E);

      // Write then read a second location.
      run_a(1'b1, 32'h1000_0024, 32'h0000_0009, nwe, noe, nerr, ncs, dat, rat, rd);
      run_a(1'b0, 32'h1000_0024, 32'h0, nwe, noe, nerr, ncs, dat, rat, rd);
      check("rd2_data", rd, 32'h0000_0009);

      // Misaligned request.
      run_a(1'b0, 32'h1000_0026, 32'h0, nwe, noe, nerr, ncs, dat, rat, rd);
      check("mis_err_cycles", 32'(nerr), 32'd1);
      check("mis_cs_cycles", 32'(ncs), 32'd0);
      check("mis_no_done", 32'(dat), 32'd0);
      check("mis_ready_at", 32'(rat), 32'd2);
      check("mis_rdata_kept", a_if.rdata, 32'h0000_0009);

      // req held high with a new address every cycle.
      @(negedge clk);
      a_if.req = 1'b1; a_if.req_we = 1'b0;
      for (int i = 0; i < 14; i++) begin
         a_if.req_addr = addrs[i % 4];
         if (a_if.ready) acc.push_back(i);
         @(negedge clk);
      end
      a_if.req = 1'b0;
      wait_idle_a();
      check("hold_req_accepts", 32'(acc.size()), 32'd3);
      if (acc.size() >= 3) begin
         check("b2b_gap1", 32'(acc[1] - acc[0]), 32'(W + 4));
         check("b2b_gap2", 32'(acc[2] - acc[1]), 32'(W + 4));
      end
      check("hold_req_last_rdata", a_if.rdata, 32'h0000_000E);

      // Reset during the ACCESS phase of a write.
      @(negedge clk);
      a_if.req = 1'b1; a_if.req_we = 1'b1;
      a_if.req_addr = 32'h0040_0024; a_if.req_wdata = 32'h55AA_55AA;
      @(negedge clk);
      a_if.req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_cs", 32'(a_cs), 32'd0);
      check("rst_mid_we", 32'(a_we), 32'd0);
      check("rst_mid_oe", 32'(a_oe), 32'd0);
      check("rst_mid_ready", 32'(a_if.ready), 32'd1);
      check("rst_mid_rdata", a_if.rdata, 32'd0);
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         if (a_if.done) ndone++;
         @(negedge clk);
      end
      check("rst_mid_no_done", 32'(ndone), 32'd0);
      run_a(1'b0, 32'h0040_0020, 32'h0, nwe, noe, nerr, ncs, dat, rat, rd);
      check("post_rst_rd_data", rd, 32'h1234_5678);
      check("post_rst_done_at", 32'(dat), 32'd5);

      // WAIT_CYCLES=1 instance.
      @(negedge clk);
      b_if.req = 1'b1; b_if.req_we = 1'b0; b_if.req_addr = 32'h0040_0020;
      @(negedge clk);
      b_if.req = 1'b0;
      noe = 0; dat = 0; rat = 0; rd = '0;
      for (int k = 1; k < 40; k++) begin
         if (b_oe) noe++;
         if (b_if.done) begin dat = k; rd = b_if.rdata; end
         if (b_if.ready) begin rat = k; break; end
         @(negedge clk);
      end
      check("w1_oe_cycles", 32'(noe), 32'd1);
      check("w1_done_at", 32'(dat), 32'd4);
      check("w1_ready_at", 32'(rat), 32'd5);
      check("w1_rdata", rd, 32'h1234_5678);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- Synchronous initiator for the asynchronous `sram` model (ports cs/oe/we/addr/din/dout).
- Accepts single-word read/write requests from a CPU-side req/ready handshake.
- Sequences SRAM control strobes through setup, access-wait, hold and done phases, and returns read data with a one-cycle done pulse.
- Sits between the datapath load/store unit and the data/instruction SRAM.

Parameters:
- ADDR_W, 32, address width (byte address).
- DATA_W, 32, data width (one word).
- WAIT_CYCLES, 2, number of cycles oe/we are held asserted in ACCESS; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  1  request valid from CPU side.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_W  byte address; must be word aligned.
- req_wdata  input  DATA_W  write data.
- ready  output  1  controller idle, can accept a request.
- done  output  1  one-cycle pulse: access completed.
- err  output  1  one-cycle pulse: request rejected (misaligned).
- rdata  output  DATA_W  read data; valid when done=1 for a read, held until next read completes.
- sram_cs  output  1  to sram cs.
- sram_oe  output  1  to sram oe.
- sram_we  output  1  to sram we.
- sram_addr  output  ADDR_W  to sram addr.
- sram_din  output  DATA_W  to sram din.
- sram_dout  input  DATA_W  from sram dout.

Behaviour:
- All outputs registered. Reset values: ready=1, done=0, err=0, rdata=0, sram_cs=0, sram_oe=0, sram_we=0, sram_addr=0, sram_din=0. State=IDLE, wait counter=0.
- Request is accepted on a rising edge where req=1 and ready=1. Addr, we and wdata are latched at that edge. req while ready=0 is ignored; no queueing.
- States and transitions:
  - IDLE: ready=1. On accept with req_addr[1:0]!=0, go to ERR. On accept otherwise, go to SETUP.
  - ERR: err=1 for one cycle, no SRAM strobe asserted, ready=0. Next state IDLE.
  - SETUP (1 cycle): sram_cs=1, sram_addr/sram_din driven, sram_oe=0, sram_we=0. Next state ACCESS, counter=WAIT_CYCLES-1.
  - ACCESS (WAIT_CYCLES cycles): sram_cs=1. sram_oe=1 for a read; sram_we=1 for a write. Counter decrements each cycle. On the edge ending the cycle where counter==0:
    - For a read, rdata <= sram_dout.
    - Next state HOLD.
  - HOLD (1 cycle): sram_cs=1, sram_oe=0, sram_we=0, addr/din unchanged (data hold after we deassert). Next state DONE.
  - DONE (1 cycle): sram_cs=0, done=1, ready=0. Next state IDLE.
- Latency: with accept at edge E0, done is high in cycle WAIT_CYCLES+3 after E0. With the default, that is 5 cycles. Back-to-back throughput is one access per WAIT_CYCLES+4 cycles (accept in IDLE cycle included).
- sram_addr and sram_din keep their last values outside an access. sram_dout is sampled only at the capture edge; X/Z at other times has no effect.
- sram_we and sram_oe are never both 1. sram_we is never 1 while sram_cs=0.
- rst asserted in any state: on the next edge, state=IDLE and all outputs return to reset values. An in-flight write may be truncated, no done is issued, and rdata is cleared.
- WAIT_CYCLES=1: ACCESS lasts exactly one cycle; the counter is never decremented below 0.

Test Plan:
- Write 0x0000000E to 0x0040003C with WAIT_CYCLES=2 -> sram_we high exactly 2 cycles with cs=1, addr=0x0040003C, din=0x0000000E. oe stays 0. done pulses 5 cycles after accept. ready returns 1 the cycle after done.
- Read back 0x0040003C (sram model preloaded with the data file) -> oe high 2 cycles. done pulses with rdata=0x0000000E, which holds after done falls. Write 0x00000009 to 0x10000024 then read 0x10000024 -> rdata=0x00000009.
- Request to 0x10000026 -> err=1 for exactly one cycle the cycle after accept. cs/oe/we stay 0. No done. rdata unchanged.
- Hold req=1 continuously with changing addresses during an access -> only addresses presented when ready=1 are issued. Second access starts exactly WAIT_CYCLES+4 cycles after the first accept.
- Assert rst for one cycle during ACCESS of a write -> next edge cs=oe=we=0, ready=1, done never pulses. A subsequent read proceeds normally.
- Rebuild with WAIT_CYCLES=1 and read 0x00400020 -> oe high exactly 1 cycle. done 4 cycles after accept. rdata equals the memory word at 0x00400020.
